// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and sequencer for the peripheral bus
// (timer, UART, FFT). One transaction in flight at a time; the address is decoded to
// a one-hot peripheral select, the slave ready is awaited with a timeout, and the
// read data / ack / error are returned to the master that owns the bus.
//
// state    | meaning
// ---------+-------------------------------------------------------------------
// S_IDLE   | no owner; arbitrate among requests, latch the winner's access
// S_ACCESS | select/strobe the peripheral, wait for ready or terminal count
// S_RESP   | one-cycle ack (with rdata/err) to the owner, update last-served

module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        m_req_i,
    input  logic [1:0]        m_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [1:0]        m_gnt_o,
    output logic [1:0]        m_ack_o,
    output logic              m_err_o,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic [ADDR_W-1:0] per_addr_o,
    output logic [DATA_W-1:0] per_wdata_o,
    output logic              per_we_o,
    output logic [2:0]        per_sel_o,
    input  logic [2:0]        per_rdy_i,
    input  logic [DATA_W-1:0] tim_data_i,
    input  logic [DATA_W-1:0] uart_data_i,
    input  logic [DATA_W-1:0] fft_data_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Timeout is a down-counter: loaded with TIMEOUT-1 on grant, terminal at zero,
    // so it can never wrap and TIMEOUT ACCESS cycles elapse before the error.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;       // 0 = M0, 1 = M1
    logic              last;        // last master served
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        sel;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic              pick;
    logic              rdy_hit;
    logic              tc;
    logic [DATA_W-1:0] per_rdata;

    // Only addr[15:12] selects a peripheral; everything else is unmapped.
    function automatic logic [2:0] decode(input logic [3:0] region);
        logic [2:0] s;
        case (region)
            4'h1:    s = 3'b001;
            4'h2:    s = 3'b010;
            4'h3:    s = 3'b100;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        pick = 1'b0;
        if (m_req_i == 2'b11) begin
            pick = ~last;
        end else begin
            pick = m_req_i[1];
        end
    end

    // Ready from the selected peripheral, terminal count and the read-data mux.
    always_comb begin
        rdy_hit   = |(per_rdy_i & sel);
        tc        = (cnt == '0);
        per_rdata = ({DATA_W{sel[0]}} & tim_data_i)
                  | ({DATA_W{sel[1]}} & uart_data_i)
                  | ({DATA_W{sel[2]}} & fft_data_i);
    end

    // Next-state decode; an unmapped select ends ACCESS after a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (|m_req_i) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if ((sel == 3'b000) || rdy_hit || tc) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning master's access at grant; address/data hold until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            sel   <= 3'b000;
        end else if ((state == S_IDLE) && (|m_req_i)) begin
            owner <= pick;
            we    <= pick ? m_we_i[1] : m_we_i[0];
            addr  <= pick ? m1_addr_i : m0_addr_i;
            wdata <= pick ? m1_wdata_i : m0_wdata_i;
            sel   <= decode(pick ? m1_addr_i[15:12] : m0_addr_i[15:12]);
        end
    end

    // Timeout counter: load on grant, count down while waiting in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == S_IDLE) && (|m_req_i)) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_ACCESS) && !tc) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response capture at the end of ACCESS; ready beats the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (state == S_ACCESS) begin
            if (sel == 3'b000) begin
                rdata <= '0;
                err   <= 1'b1;
            end else if (rdy_hit) begin
                rdata <= we ? '0 : per_rdata;
                err   <= 1'b0;
            end else if (tc) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end

    // Last-served tracking, updated when the owner is acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (state == S_RESP) begin
            last <= owner;
        end
    end

    // Outputs decode only from registered state and latches.
    always_comb begin
        m_gnt_o     = 2'b00;
        m_ack_o     = 2'b00;
        m_err_o     = 1'b0;
        m_rdata_o   = '0;
        per_we_o    = 1'b0;
        per_sel_o   = 3'b000;
        per_addr_o  = addr;
        per_wdata_o = wdata;
        if ((state == S_ACCESS) || (state == S_RESP)) begin
            m_gnt_o = owner ? 2'b10 : 2'b01;
        end
        if (state == S_ACCESS) begin
            per_sel_o = sel;
            per_we_o  = we;
        end
        if (state == S_RESP) begin
            m_ack_o   = owner ? 2'b10 : 2'b01;
            m_err_o   = err;
            m_rdata_o = rdata;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed expectations for bus_arbiter.

module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_req_i;
    logic [1:0]  m_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [1:0]  m_gnt_o, m_ack_o;
    logic        m_err_o;
    logic [31:0] m_rdata_o, per_addr_o, per_wdata_o;
    logic        per_we_o;
    logic [2:0]  per_sel_o;
    logic [2:0]  per_rdy_i;
    logic [31:0] tim_data_i, uart_data_i, fft_data_i;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m_gnt_o     (m_gnt_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .m_rdata_o   (m_rdata_o),
        .per_addr_o  (per_addr_o),
        .per_wdata_o (per_wdata_o),
        .per_we_o    (per_we_o),
        .per_sel_o   (per_sel_o),
        .per_rdy_i   (per_rdy_i),
        .tim_data_i  (tim_data_i),
        .uart_data_i (uart_data_i),
        .fft_data_i  (fft_data_i)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_bad     = 0;
    int gnt_multi = 0;

    // results of the last txn() call
    int          r_acc, r_lat;
    logic [2:0]  r_sel;
    logic        r_we, r_err;
    logic [1:0]  r_ack;
    logic [31:0] r_rdata;

    // Grant must never have both bits set.
    always @(negedge clk) begin
        if ($countones(m_gnt_o) > 1) gnt_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from master m; ready asserted during ACCESS cycle rdy_at (0 = never).
    // Ends one cycle after the ack, with the arbiter back in IDLE.
    task automatic txn(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int rdy_at);
        if (m == 0) begin
            m0_addr_i = a; m0_wdata_i = d; m_we_i[0] = w;
        end else begin
            m1_addr_i = a; m1_wdata_i = d; m_we_i[1] = w;
        end
        m_req_i[m] = 1'b1;
        per_rdy_i  = 3'b000;
        r_acc = 0; r_lat = 0; r_sel = 3'b000; r_we = 1'b0;
        r_ack = 2'b00; r_err = 1'b0; r_rdata = 32'h0;
        for (int i = 0; i < 40; i++) begin
            tick();
            r_lat++;
            if (m_ack_o != 2'b00) begin
                r_ack = m_ack_o; r_err = m_err_o; r_rdata = m_rdata_o;
                m_req_i[m] = 1'b0;
                per_rdy_i  = 3'b000;
                break;
            end
            if (m_gnt_o != 2'b00) begin
                r_acc++;
                r_sel = r_sel | per_sel_o;
                r_we  = r_we | per_we_o;
                per_rdy_i = (r_acc == rdy_at) ? 3'b111 : 3'b000;
            end
        end
        m_req_i[m] = 1'b0;
        tick();
    endtask

    logic [1:0] order [4];
    int         n_got;
    logic [1:0] first_ack;

    initial begin
        rst_n = 1'b0;
        m_req_i = 2'b00; m_we_i = 2'b00;
        m0_addr_i = 32'h0; m0_wdata_i = 32'h0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0;
        per_rdy_i = 3'b000;
        tim_data_i = 32'hDEAD_BEEF; uart_data_i = 32'h1234_5678; fft_data_i = 32'hCAFE_F00D;
        tick(); tick();

        chk("rst_gnt",   32'(m_gnt_o), 32'h0);
        chk("rst_ack",   32'(m_ack_o), 32'h0);
        chk("rst_sel",   32'(per_sel_o), 32'h0);
        chk("rst_we",    32'(per_we_o), 32'h0);
        chk("rst_err",   32'(m_err_o), 32'h0);
        chk("rst_rdata", m_rdata_o, 32'h0);
        chk("rst_addr",  per_addr_o, 32'h0);
        chk("rst_wdata", per_wdata_o, 32'h0);
        rst_n = 1'b1;
        tick();

        // M0 timer read, ready in the first ACCESS cycle
        txn(0, 1'b0, 32'h0000_1004, 32'h0, 1);
        chk("t1_lat",   32'(r_lat), 32'd2);
        chk("t1_acc",   32'(r_acc), 32'd1);
        chk("t1_sel",   32'(r_sel), 32'b001);
        chk("t1_we",    32'(r_we), 32'h0);
        chk("t1_ack",   32'(r_ack), 32'b01);
        chk("t1_err",   32'(r_err), 32'h0);
        chk("t1_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("t1_idle",  32'(m_gnt_o), 32'h0);

        // M1 UART write, ready after 3 waiting cycles
        txn(1, 1'b1, 32'h0000_2000, 32'h55, 4);
        chk("t2_acc",   32'(r_acc), 32'd4);
        chk("t2_lat",   32'(r_lat), 32'd5);
        chk("t2_sel",   32'(r_sel), 32'b010);
        chk("t2_we",    32'(r_we), 32'h1);
        chk("t2_ack",   32'(r_ack), 32'b10);
        chk("t2_err",   32'(r_err), 32'h0);
        chk("t2_rdata", r_rdata, 32'h0);
        chk("t2_wdata_hold", per_wdata_o, 32'h55);
        chk("t2_addr_hold",  per_addr_o, 32'h0000_2000);
        m_we_i = 2'b00;

        // M0 FFT read, never ready -> timeout after 16 ACCESS cycles
        txn(0, 1'b0, 32'h0000_3000, 32'h0, 0);
        chk("t4_acc",   32'(r_acc), 32'd16);
        chk("t4_lat",   32'(r_lat), 32'd17);
        chk("t4_sel",   32'(r_sel), 32'b100);
        chk("t4_ack",   32'(r_ack), 32'b01);
        chk("t4_err",   32'(r_err), 32'h1);
        chk("t4_rdata", r_rdata, 32'h0);

        // M1 FFT read, ready in the 16th (last) ACCESS cycle -> success
        txn(1, 1'b0, 32'h0000_3010, 32'h0, 16);
        chk("tlast_acc",   32'(r_acc), 32'd16);
        chk("tlast_err",   32'(r_err), 32'h0);
        chk("tlast_rdata", r_rdata, 32'hCAFE_F00D);

        // M1 unmapped access; ready asserted anyway must not matter
        txn(1, 1'b0, 32'h0000_7000, 32'h0, 1);
        chk("t5_acc",   32'(r_acc), 32'd1);
        chk("t5_lat",   32'(r_lat), 32'd2);
        chk("t5_sel",   32'(r_sel), 32'b000);
        chk("t5_ack",   32'(r_ack), 32'b10);
        chk("t5_err",   32'(r_err), 32'h1);
        chk("t5_rdata", r_rdata, 32'h0);

        // Only addr[15:12] decodes: upper bits ignored, region 0 unmapped
        txn(0, 1'b0, 32'hABCD_2FFC, 32'h0, 2);
        chk("dec_uart_sel",   32'(r_sel), 32'b010);
        chk("dec_uart_rdata", r_rdata, 32'h1234_5678);
        txn(0, 1'b0, 32'h0000_0FFF, 32'h0, 1);
        chk("dec_low_sel", 32'(r_sel), 32'b000);
        chk("dec_low_err", 32'(r_err), 32'h1);

        // Both masters requesting continuously from reset -> M0,M1,M0,M1
        rst_n = 1'b0;
        m0_addr_i = 32'h0000_1000; m1_addr_i = 32'h0000_2000;
        m_we_i = 2'b00; m_req_i = 2'b11; per_rdy_i = 3'b111;
        tick();
        rst_n = 1'b1;
        n_got = 0;
        for (int i = 0; i < 4; i++) order[i] = 2'b00;
        for (int i = 0; i < 30 && n_got < 4; i++) begin
            tick();
            if (m_ack_o != 2'b00) begin
                order[n_got] = m_ack_o;
                n_got++;
            end
        end
        chk("t3_ord0", 32'(order[0]), 32'b01);
        chk("t3_ord1", 32'(order[1]), 32'b10);
        chk("t3_ord2", 32'(order[2]), 32'b01);
        chk("t3_ord3", 32'(order[3]), 32'b10);
        m_req_i = 2'b00; per_rdy_i = 3'b000;
        tick(); tick();

        // Reset during ACCESS of an M1 UART write
        m1_addr_i = 32'h0000_2000; m1_wdata_i = 32'h55; m_we_i = 2'b10; m_req_i = 2'b10;
        tick();
        chk("t6_sel_acc", 32'(per_sel_o), 32'b010);
        chk("t6_we_acc",  32'(per_we_o), 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_sel_rst", 32'(per_sel_o), 32'h0);
        chk("t6_we_rst",  32'(per_we_o), 32'h0);
        chk("t6_gnt_rst", 32'(m_gnt_o), 32'h0);
        chk("t6_ack_rst", 32'(m_ack_o), 32'h0);
        m0_addr_i = 32'h0000_1004; m_we_i = 2'b00; m_req_i = 2'b11; per_rdy_i = 3'b111;
        tick(); tick();
        rst_n = 1'b1;
        first_ack = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_ack_o != 2'b00) begin
                first_ack = m_ack_o;
                break;
            end
        end
        chk("t6_post_rst_tie", 32'(first_ack), 32'b01);
        m_req_i = 2'b00; per_rdy_i = 3'b000;
        tick();

        chk("gnt_onehot", 32'(gnt_multi), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
